// File: rtl/tnkiii_front_pkg.sv
// Shared constants and FSM encoding for the front-layer line buffer.
// Optional first-wins priority: define FRONT_LB_FIRST_WINS_EN.
package tnkiii_front_pkg;

  localparam logic [2:0] TRANSP_CODE = 3'b111;
  localparam logic [6:0] CLEAR_ENTRY = 7'h7F;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/tnkiii_linebuf_bank.sv
// One line-buffer bank: sprite write port plus read-then-clear port.
// FRONT_LB_FIRST_WINS_EN adds per-entry occupied flags.
module tnkiii_linebuf_bank
  import tnkiii_front_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  VIDEO_RSTn,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [6:0]            wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [6:0]            rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [6:0] mem [DEPTH];
  logic       wr_ok;

`ifdef FRONT_LB_FIRST_WINS_EN
  logic [DEPTH-1:0] occ;

  assign wr_ok = we & ~occ[waddr];

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      occ <= '0;
    end else begin
      if (wr_ok) occ[waddr] <= 1'b1;
      if (re)    occ[raddr] <= 1'b0;
    end
  end
`else
  assign wr_ok = we;
`endif

  // Read and write never target the same bank in one clk
  always_ff @(posedge clk) begin
    if (re)         mem[raddr] <= CLEAR_ENTRY;
    else if (wr_ok) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn)  rdata <= CLEAR_ENTRY;
    else if (re)      rdata <= mem[raddr];
  end

endmodule

// File: rtl/tnkiii_front_linebuf.sv
// Double-banked front sprite line buffer with row-write FSM.
// Optional first-wins priority: define FRONT_LB_FIRST_WINS_EN.
module tnkiii_front_linebuf
  import tnkiii_front_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int SPR_W      = 16
) (
  input  logic                  clk,
  input  logic                  VIDEO_RSTn,
  input  logic [7:0]            FD,
  input  logic [8:0]            FL_Y,
  input  logic                  pix_cen,
  input  logic                  spr_start,
  input  logic                  line_swap,
  input  logic [ADDR_WIDTH-1:0] rd_x,
  input  logic                  rd_cen,
  output logic [6:0]            FRONT_PIX,
  output logic                  busy
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(SPR_W - 1);

  wr_state_t             state;
  logic [ADDR_WIDTH-1:0] x_base;
  logic [CW-1:0]         cnt;
  logic                  bank_sel;
  logic                  rd_sel;
  logic                  pix_ok;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [6:0]            wdata;
  logic [6:0]            rd0;
  logic [6:0]            rd1;
  logic                  unused_fd7;

  assign unused_fd7 = FD[7];

  // Swap or restart on the same clk drops the pixel
  assign pix_ok = pix_cen & (state == WRITE)
                & ~spr_start & ~line_swap;
  assign wr_en  = pix_ok & (FD[2:0] != TRANSP_CODE);
  assign waddr  = x_base + ADDR_WIDTH'(cnt);
  assign wdata  = {FD[6:3], FD[2:0]};
  assign busy   = (state == WRITE);

  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn) begin
      state    <= IDLE;
      x_base   <= '0;
      cnt      <= '0;
      bank_sel <= 1'b0;
    end else begin
      priority case (1'b1)
        line_swap: begin
          bank_sel <= ~bank_sel;
          state    <= IDLE;
          cnt      <= '0;
        end
        spr_start: begin
          x_base <= ADDR_WIDTH'(FL_Y);
          cnt    <= '0;
          state  <= WRITE;
        end
        pix_ok: begin
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Remember which bank the last read came from
  always_ff @(posedge clk or negedge VIDEO_RSTn) begin
    if (!VIDEO_RSTn)  rd_sel <= 1'b0;
    else if (rd_cen)  rd_sel <= ~bank_sel;
  end

  assign FRONT_PIX = rd_sel ? rd1 : rd0;

  tnkiii_linebuf_bank #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank0 (
    .clk        (clk),
    .VIDEO_RSTn (VIDEO_RSTn),
    .we         (wr_en & ~bank_sel),
    .waddr      (waddr),
    .wdata      (wdata),
    .re         (rd_cen & bank_sel),
    .raddr      (rd_x),
    .rdata      (rd0)
  );

  tnkiii_linebuf_bank #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank1 (
    .clk        (clk),
    .VIDEO_RSTn (VIDEO_RSTn),
    .we         (wr_en & bank_sel),
    .waddr      (waddr),
    .wdata      (wdata),
    .re         (rd_cen & ~bank_sel),
    .raddr      (rd_x),
    .rdata      (rd1)
  );

endmodule

// File: tb/tb_tnkiii_front_linebuf.sv
// Scoreboard bench for tnkiii_front_linebuf against a
// line-level model (two arrays, current write bank, row cursor).
module tb_tnkiii_front_linebuf;

  localparam int DEPTH = 512;
  localparam int SPR   = 16;
`ifdef FRONT_LB_FIRST_WINS_EN
  localparam bit FW = 1'b1;
`else
  localparam bit FW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       VIDEO_RSTn;
  logic [7:0] FD;
  logic [8:0] FL_Y;
  logic       pix_cen;
  logic       spr_start;
  logic       line_swap;
  logic [8:0] rd_x;
  logic       rd_cen;
  logic [6:0] FRONT_PIX;
  logic       busy;

  always #5 clk = ~clk;

  tnkiii_front_linebuf dut (
    .clk        (clk),
    .VIDEO_RSTn (VIDEO_RSTn),
    .FD         (FD),
    .FL_Y       (FL_Y),
    .pix_cen    (pix_cen),
    .spr_start  (spr_start),
    .line_swap  (line_swap),
    .rd_x       (rd_x),
    .rd_cen     (rd_cen),
    .FRONT_PIX  (FRONT_PIX),
    .busy       (busy)
  );

  int tests = 0;
  int fails = 0;

  logic [6:0] mdl [2][DEPTH];
  int         wb;
  bit         row_on;
  int         row_x;
  int         row_n;
  bit         exp_busy;
  bit         dc_mode;
  logic [7:0] sbq [$];

  task automatic check(string name, logic [6:0] act,
                       logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < DEPTH; a++)
        mdl[b][a] = 7'h7F;
    wb = 0;
    row_on = 0;
    row_n = 0;
    exp_busy = 0;
    sbq.delete();
  endtask

  task automatic drive0();
    FD = 0; FL_Y = 0; pix_cen = 0; spr_start = 0;
    line_swap = 0; rd_x = 0; rd_cen = 0;
  endtask

  // One clk of stimulus; the model follows the line-level rules
  task automatic cyc(bit sw, bit st, logic [8:0] fy, bit pc,
                     logic [7:0] fd, bit rc, logic [8:0] rx);
    int a;
    @(negedge clk);
    line_swap = sw; spr_start = st; FL_Y = fy;
    pix_cen = pc; FD = fd; rd_cen = rc; rd_x = rx;
    if (rc) begin
      if (dc_mode) sbq.push_back(8'h80);
      else sbq.push_back({1'b0, mdl[1-wb][rx]});
      mdl[1-wb][rx] = 7'h7F;
    end
    if (sw) begin
      row_on = 0;
      wb = 1 - wb;
    end else if (st) begin
      row_on = 1;
      row_x = int'(fy);
      row_n = 0;
    end else if (pc && row_on) begin
      if (fd[2:0] != 3'b111) begin
        a = (row_x + row_n) % DEPTH;
        if (!FW || mdl[wb][a] == 7'h7F)
          mdl[wb][a] = {fd[6:3], fd[2:0]};
      end
      row_n++;
      if (row_n == SPR) row_on = 0;
    end
    exp_busy = row_on;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic swap();
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(logic [8:0] x);
    cyc(0, 0, 0, 0, 0, 1, x);
  endtask

  task automatic rd_chk(string name, logic [8:0] x,
                        logic [6:0] exp);
    rd(x);
    @(posedge clk);
    #2;
    check(name, FRONT_PIX, exp);
  endtask

  task automatic row(logic [8:0] x, logic [7:0] fd,
                     bit vary, int npix);
    logic [7:0] f;
    cyc(0, 1, x, 0, 0, 0, 0);
    for (int i = 0; i < npix; i++) begin
      f = vary ? {1'b0, 4'(i), 3'(i % 7)} : fd;
      cyc(0, 0, 0, 1, f, 0, 0);
      idle(1);
    end
  endtask

  task automatic clear_pass(bit dc);
    dc_mode = dc;
    for (int x = 0; x < DEPTH; x++) rd(9'(x));
    swap();
    for (int x = 0; x < DEPTH; x++) rd(9'(x));
    dc_mode = 0;
    idle(2);
  endtask

  // Monitor: pops the scoreboard on every read strobe
  initial begin
    logic [7:0] e;
    bit         fire;
    logic [6:0] last;
    bit         last_dc;
    last = 7'h7F;
    last_dc = 0;
    forever begin
      @(posedge clk);
      fire = rd_cen;
      #2;
      if (!VIDEO_RSTn) begin
        last = 7'h7F;
        last_dc = 0;
      end else begin
        check("busy", {6'b0, busy}, {6'b0, exp_busy});
        if (fire) begin
          if (sbq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_empty: read with no expectation");
          end else begin
            e = sbq.pop_front();
            last_dc = e[7];
            last = e[6:0];
            if (!e[7]) check("rd", FRONT_PIX, last);
          end
        end else if (!last_dc) begin
          check("hold", FRONT_PIX, last);
        end
      end
    end
  end

  initial begin
    logic [6:0] ev;
    bit         prev;
    bit         sw, st, pc;
    drive0();
    model_reset();
    dc_mode = 0;
    VIDEO_RSTn = 1'b1;
    #1 VIDEO_RSTn = 1'b0;
    #2;
    check("rst_pix", FRONT_PIX, 7'h7F);
    check("rst_busy", {6'b0, busy}, 7'h00);
    repeat (2) @(negedge clk);
    VIDEO_RSTn = 1'b1;

    clear_pass(1);

    // Basic row at 0x20
    row(9'h020, 8'h0A, 0, SPR);
    idle(1);
    swap();
    rd_chk("base_1f", 9'h01F, 7'h7F);
    for (int x = 'h20; x <= 'h2F; x++)
      rd_chk("base_in", 9'(x), 7'h0A);
    rd_chk("base_30", 9'h030, 7'h7F);
    idle(2);

    // Row wrapping past the top of the buffer
    row(9'h1F8, 8'h00, 1, SPR);
    idle(1);
    swap();
    for (int k = 0; k < 18; k++) begin
      int i;
      i = k - 1;
      if (i >= 0 && i < SPR) ev = {4'(i), 3'(i % 7)};
      else ev = 7'h7F;
      rd_chk("wrap", 9'((9'h1F7 + k) % DEPTH), ev);
    end
    idle(2);

    // Overlapping rows
    row(9'h040, 8'h09, 0, SPR);
    row(9'h044, 8'h31, 0, SPR);
    idle(1);
    swap();
`ifdef FRONT_LB_FIRST_WINS_EN
    rd_chk("overlap_44", 9'h044, 7'h09);
`else
    rd_chk("overlap_44", 9'h044, 7'h31);
`endif
    rd_chk("overlap_40", 9'h040, 7'h09);
    rd_chk("overlap_53", 9'h053, 7'h31);
    idle(2);

    // Swap after 5 of 16 pixels
    row(9'h080, 8'h11, 0, 5);
    check("busy_mid", {6'b0, busy}, 7'h01);
    swap();
    @(posedge clk);
    #2;
    check("busy_drop", {6'b0, busy}, 7'h00);
    for (int x = 'h80; x <= 'h8F; x++)
      rd_chk("partial", 9'(x),
             (x < 'h85) ? 7'h11 : 7'h7F);
    idle(2);

    // Second read pass of an unwritten bank is transparent
    clear_pass(0);
    swap();
    for (int x = 0; x < DEPTH; x++)
      rd_chk("second_pass", 9'(x), 7'h7F);
    idle(2);

    // Randomised traffic against the model
    prev = 0;
    for (int n = 0; n < 3000; n++) begin
      sw = ($urandom % 60) == 0;
      st = !sw && (($urandom % 25) == 0);
      pc = !sw && !prev && (($urandom % 2) == 0);
      prev = pc;
      cyc(sw, st, 9'($urandom), pc, 8'($urandom),
          ($urandom % 3) == 0, 9'($urandom % DEPTH));
    end
    idle(2);

    // Asynchronous reset in the middle of a row
    clear_pass(0);
    row(9'h100, 8'h2B, 0, SPR);
    idle(1);
    swap();
    rd_chk("pre_rst", 9'h100, 7'h2B);
    row(9'h120, 8'h0C, 0, 3);
    @(posedge clk);
    #3;
    VIDEO_RSTn = 1'b0;
    drive0();
    model_reset();
    #1;
    check("arst_busy", {6'b0, busy}, 7'h00);
    check("arst_pix", FRONT_PIX, 7'h7F);
    repeat (2) @(negedge clk);
    VIDEO_RSTn = 1'b1;

    clear_pass(1);
    row(9'h010, 8'h4D, 0, SPR);
    idle(1);
    swap();
    rd_chk("post_rst", 9'h01F, 7'h4D);
    idle(3);
    check("sb_drain", 7'(sbq.size()), 7'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
